// File: rtl/reg_bank_pkg.sv
// Shared types and the half-word merge helper for the reg_bank register file.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_LO   = 2'b01,
    WR_HI   = 2'b10,
    WR_FULL = 2'b11
  } wr_mode_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Widest word the merge helper handles; callers zero-extend and keep the low WIDTH bits.
  localparam int unsigned MAX_W = 256;

  function automatic logic [MAX_W-1:0] half_merge(input logic [MAX_W-1:0] old_word,
                                                  input logic [MAX_W-1:0] new_word,
                                                  input wr_mode_e         mode,
                                                  input int unsigned      width);
    logic [MAX_W-1:0] lo_mask;
    logic [MAX_W-1:0] merged;
    lo_mask = (MAX_W'(1) << (width / 2)) - MAX_W'(1);
    case (mode)
      WR_LO:   merged = (old_word & ~lo_mask) | (new_word & lo_mask);
      WR_HI:   merged = (new_word & ~lo_mask) | (old_word & lo_mask);
      WR_FULL: merged = new_word;
      default: merged = old_word;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/reg_bank_clear_seq.sv
// Clear sequencer for reg_bank: walks an index 0..DEPTH-1, strobing one zeroing write per cycle.
module reg_bank_clear_seq
  import reg_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign clr_we  = busy;
  assign clr_idx = cnt_q;

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: staged write port with read forwarding, sequenced clear.
// Optional REG_BANK_ZERO_HARDWIRED_EN makes register 0 read as zero and ignore writes.
module reg_bank #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned NREAD = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             reg_write,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   clear_req,
  output logic                   busy,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data
);
  import reg_bank_pkg::*;

  logic          clr_we;
  logic [AW-1:0] clr_idx;

  reg_bank_clear_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_clear_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  assign wr_ready = ~busy;

  logic wr_blocked;
`ifdef REG_BANK_ZERO_HARDWIRED_EN
  assign wr_blocked = (wr_addr == '0);
`else
  assign wr_blocked = 1'b0;
`endif

  logic wr_accept;
  assign wr_accept = wr_ready && (reg_write != WR_NONE) && (32'(wr_addr) < DEPTH) && !wr_blocked;

  logic             stage_valid_q;
  logic [AW-1:0]    stage_addr_q;
  wr_mode_e         stage_mode_q;
  logic [WIDTH-1:0] stage_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_mode_q  <= WR_NONE;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= wr_accept;
      if (wr_accept) begin
        stage_addr_q <= wr_addr;
        stage_mode_q <= wr_mode_e'(reg_write);
        stage_data_q <= wr_data;
      end
    end
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [MAX_W-1:0] commit_full;

  assign commit_full = half_merge(MAX_W'(mem_q[stage_addr_q]), MAX_W'(stage_data_q),
                                  stage_mode_q, WIDTH);

  // Clear write is ordered last so it wins if both target the same entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (stage_valid_q) begin
        mem_q[stage_addr_q] <= commit_full[WIDTH-1:0];
      end
      if (clr_we) begin
        mem_q[clr_idx] <= '0;
      end
    end
  end

  logic [AW-1:0]    rd_idx   [NREAD];
  logic [MAX_W-1:0] fwd_full [NREAD];
  logic             rd_blocked;

  always_comb begin
    rd_data    = '0;
    rd_blocked = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      rd_idx[i]   = rd_addr[i*AW +: AW];
      fwd_full[i] = MAX_W'(mem_q[rd_idx[i]]);
      if (stage_valid_q && (stage_addr_q == rd_idx[i])) begin
        fwd_full[i] = half_merge(fwd_full[i], MAX_W'(stage_data_q), stage_mode_q, WIDTH);
      end
`ifdef REG_BANK_ZERO_HARDWIRED_EN
      rd_blocked = (rd_idx[i] == '0);
`endif
      if ((32'(rd_idx[i]) < DEPTH) && !rd_blocked) begin
        rd_data[i*WIDTH +: WIDTH] = fwd_full[i][WIDTH-1:0];
      end
    end
  end

  // Upper bits of the zero-extended merge results carry no information.
  logic unused_hi;
  always_comb begin
    unused_hi = ^commit_full[MAX_W-1:WIDTH];
    for (int i = 0; i < NREAD; i++) begin
      unused_hi = unused_hi ^ (^fwd_full[i][MAX_W-1:WIDTH]);
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic vs a behavioural model.
`timescale 1ns/1ps
module tb_reg_bank;

  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

`ifdef REG_BANK_ZERO_HARDWIRED_EN
  localparam logic [31:0] ZERO_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] ZERO_EXP = 32'hFFFF_FFFF;
`endif

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [1:0]             reg_write;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_ready;
  logic                   clear_req;
  logic                   busy;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;

  reg_bank #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .NREAD(NREAD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reg_write(reg_write),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clear_req(clear_req),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents, one pending write, clear position (-1 when idle).
  logic [31:0] m_mem [DEPTH];
  bit          p_valid;
  int          p_addr;
  logic [1:0]  p_mode;
  logic [31:0] p_data;
  int          clr_pos;
  bit          chk_en;
  int          checks;
  int          errors;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [1:0] mode);
    return {(mode[1] ? n[31:16] : o[31:16]), (mode[0] ? n[15:0] : o[15:0])};
  endfunction

  function automatic bit zero_hw(input int a);
`ifdef REG_BANK_ZERO_HARDWIRED_EN
    return (a == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    logic [31:0] w;
    if (a >= DEPTH || zero_hw(a)) return 32'h0;
    w = m_mem[a];
    if (p_valid && p_addr == a) w = merge(w, p_data, p_mode);
    return w;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 32'h0;
    p_valid = 1'b0;
    p_addr  = 0;
    p_mode  = 2'b00;
    p_data  = 32'h0;
    clr_pos = -1;
  endtask

  task automatic model_edge();
    if (p_valid) m_mem[p_addr] = merge(m_mem[p_addr], p_data, p_mode);
    if (clr_pos >= 0) begin
      m_mem[clr_pos] = 32'h0;
      p_valid        = 1'b0;
      clr_pos        = (clr_pos == DEPTH - 1) ? -1 : clr_pos + 1;
    end else begin
      p_valid = (reg_write != 2'b00) && (int'(wr_addr) < DEPTH) && !zero_hw(int'(wr_addr));
      p_addr  = int'(wr_addr);
      p_mode  = reg_write;
      p_data  = wr_data;
      if (clear_req) clr_pos = 0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic set_rd(input int port, input int a);
    rd_addr[port*AW +: AW] = AW'(a);
  endtask

  function automatic logic [31:0] get_rd(input int port);
    return rd_data[port*WIDTH +: WIDTH];
  endfunction

  task automatic sweep_zero(input string name);
    for (int a = 0; a < DEPTH; a += 2) begin
      cyc();
      set_rd(0, a);
      set_rd(1, a + 1);
      @(negedge clk);
      check(name, 64'(get_rd(0)), 64'h0);
      check(name, 64'(get_rd(1)), 64'h0);
    end
  endtask

  // Model compare on every falling edge once reset has been released.
  initial forever begin
    @(negedge clk);
    if (chk_en && reset_n) begin
      check("busy", 64'(busy), 64'(clr_pos >= 0));
      check("wr_ready", 64'(wr_ready), 64'(clr_pos < 0));
      for (int i = 0; i < NREAD; i++) begin
        check($sformatf("rd_data%0d", i), 64'(get_rd(i)),
              64'(exp_rd(int'(rd_addr[i*AW +: AW]))));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] d30;
    checks    = 0;
    errors    = 0;
    chk_en    = 1'b0;
    reset_n   = 1'b1;
    reg_write = 2'b00;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;
    rd_addr   = '0;
    model_reset();
    #2 reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_wr_ready", 64'(wr_ready), 64'h1);
    sweep_zero("reset_rd");

    // Full write, forwarded then from the array
    cyc();
    reg_write = 2'b11; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; set_rd(0, 5);
    cyc();
    reg_write = 2'b00;
    @(negedge clk);
    check("fwd_full", 64'(get_rd(0)), 64'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    check("array_full", 64'(get_rd(0)), 64'hDEAD_BEEF);

    // Half writes LO then HI to one address
    cyc();
    reg_write = 2'b01; wr_addr = 5'd3; wr_data = 32'h0000_1234; set_rd(1, 3);
    cyc();
    reg_write = 2'b10; wr_addr = 5'd3; wr_data = 32'hABCD_0000;
    @(negedge clk);
    check("half_lo", 64'(get_rd(1)), 64'h0000_1234);
    cyc();
    reg_write = 2'b00;
    @(negedge clk);
    check("half_merged_fwd", 64'(get_rd(1)), 64'hABCD_1234);
    cyc();
    @(negedge clk);
    check("half_merged_arr", 64'(get_rd(1)), 64'hABCD_1234);

    // Register 0 write
    cyc();
    reg_write = 2'b11; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; set_rd(0, 0);
    cyc();
    reg_write = 2'b00;
    @(negedge clk);
    check("reg0_fwd", 64'(get_rd(0)), 64'(ZERO_EXP));
    cyc();
    @(negedge clk);
    check("reg0_arr", 64'(get_rd(0)), 64'(ZERO_EXP));

    // Fill 1..31, then a full clear with a dropped write inside the window
    for (int a = 1; a < DEPTH; a++) begin
      cyc();
      reg_write = 2'b11; wr_addr = AW'(a); wr_data = $urandom | 32'h1;
    end
    cyc();
    reg_write = 2'b00; clear_req = 1'b1; set_rd(0, 7); set_rd(1, 31);
    cyc();
    clear_req = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      cyc();
      reg_write = (n == 5) ? 2'b11 : 2'b00;
      wr_addr   = 5'd7;
      wr_data   = 32'h1234_5678;
    end
    reg_write = 2'b00;
    check("clear_busy_cycles", 64'(n), 64'd32);
    check("clear_wr_ready_after", 64'(wr_ready), 64'h1);
    sweep_zero("after_clear");

    // Second clear, abandoned by reset in its tenth cycle
    foreach (m_mem[a]) begin end
    for (int j = 0; j < 4; j++) begin
      cyc();
      reg_write = 2'b11;
      wr_addr   = (j == 0) ? 5'd2 : (j == 1) ? 5'd9 : (j == 2) ? 5'd17 : 5'd30;
      wr_data   = $urandom | 32'h1;
      if (j == 3) d30 = wr_data;
    end
    cyc();
    reg_write = 2'b00; clear_req = 1'b1; set_rd(0, 30); set_rd(1, 17);
    cyc();
    clear_req = 1'b0;
    repeat (9) cyc();
    @(negedge clk);
    check("partial_clear_busy", 64'(busy), 64'h1);
    check("partial_clear_rd", 64'(get_rd(0)), 64'(d30));
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check("midreset_busy", 64'(busy), 64'h0);
    check("midreset_wr_ready", 64'(wr_ready), 64'h1);
    check("midreset_rd0", 64'(get_rd(0)), 64'h0);
    check("midreset_rd1", 64'(get_rd(1)), 64'h0);
    #1 reset_n = 1'b1;
    cyc();
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'h0);
    sweep_zero("post_reset_rd");

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      cyc();
      clear_req = 1'b0;
      if (clr_pos < 0 && $urandom_range(0, 99) == 0) begin
        clear_req = 1'b1;
        reg_write = 2'b00;
      end else begin
        reg_write = 2'($urandom_range(0, 3));
      end
      wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                             : AW'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      for (int i = 0; i < NREAD; i++) begin
        set_rd(i, ($urandom_range(0, 2) != 0) ? $urandom_range(0, 7)
                                             : $urandom_range(0, DEPTH - 1));
      end
    end
    cyc();
    reg_write = 2'b00;
    clear_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
